// File: rtl/bus_transfer_scheduler.sv
// bus_transfer_scheduler: round-robin scheduler for register-to-register moves
// on a shared tri-state bus. Drives active-low per-register bus-write (source)
// and bus-read (destination) enables through a DRIVE/XFER/RELEASE sequence.
// Optional build macro BUS_XFER_CHECK_EN adds o_ERROR and rejects transfers
// with src==dst or an out-of-range index in a 2-cycle IDLE->RELEASE path.
module bus_transfer_scheduler #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned NUM_REGS      = 8,
  parameter int unsigned REG_IDX_WIDTH = 3
) (
  input  logic                               i_CLOCK,
  input  logic                               i_RESET,
  input  logic [NUM_REQ-1:0]                 i_REQ,
  input  logic [NUM_REQ*REG_IDX_WIDTH-1:0]   i_SRC,
  input  logic [NUM_REQ*REG_IDX_WIDTH-1:0]   i_DST,
  output logic [NUM_REQ-1:0]                 o_GRANT,
  output logic [NUM_REQ-1:0]                 o_DONE,
  output logic [NUM_REGS-1:0]                o_WRITE_BUS_n,
  output logic [NUM_REGS-1:0]                o_READ_BUS_n,
`ifdef BUS_XFER_CHECK_EN
  output logic [NUM_REQ-1:0]                 o_ERROR,
`endif
  output logic                               o_BUSY
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_XFER    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic [PTR_W-1:0]           sel_q, sel_d;
  logic [REG_IDX_WIDTH-1:0]   src_q, src_d;
  logic [REG_IDX_WIDTH-1:0]   dst_q, dst_d;
  logic [NUM_REQ-1:0]         grant_q, grant_d;
  logic [NUM_REQ-1:0]         done_q, done_d;
  logic [NUM_REGS-1:0]        wr_n_q, wr_n_d;
  logic [NUM_REGS-1:0]        rd_n_q, rd_n_d;
  logic                       busy_q, busy_d;
`ifdef BUS_XFER_CHECK_EN
  logic [NUM_REQ-1:0]         error_q, error_d;
  logic                       req_bad;
`endif

  logic                       found;
  logic [PTR_W-1:0]           pick;
  logic [PTR_W-1:0]           cand;
  logic [REG_IDX_WIDTH-1:0]   src_sel;
  logic [REG_IDX_WIDTH-1:0]   dst_sel;

  // Active-low one-cold enable for a register index; out-of-range drives nothing.
  function automatic logic [NUM_REGS-1:0] enable_n(input logic [REG_IDX_WIDTH-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '1;
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      if (idx == REG_IDX_WIDTH'(r)) v[r] = 1'b0;
    end
    return v;
  endfunction

  // Round-robin search: first set request at or above the pointer, with wrap.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = ptr_q;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = PTR_W'((32'(ptr_q) + 32'(i)) % NUM_REQ);
      if (!found && i_REQ[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    src_sel = i_SRC[32'(pick)*REG_IDX_WIDTH +: REG_IDX_WIDTH];
    dst_sel = i_DST[32'(pick)*REG_IDX_WIDTH +: REG_IDX_WIDTH];
  end

  // Next state and next registered outputs, computed for the state being entered.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    src_d   = src_q;
    dst_d   = dst_q;
    grant_d = grant_q;
    done_d  = '0;
    wr_n_d  = '1;
    rd_n_d  = '1;
`ifdef BUS_XFER_CHECK_EN
    error_d = '0;
    req_bad = (src_sel == dst_sel) || (32'(src_sel) >= NUM_REGS) ||
              (32'(dst_sel) >= NUM_REGS);
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          sel_d        = pick;
          src_d        = src_sel;
          dst_d        = dst_sel;
          grant_d      = '0;
          grant_d[pick] = 1'b1;
`ifdef BUS_XFER_CHECK_EN
          if (req_bad) begin
            state_d       = S_RELEASE;
            error_d[pick] = 1'b1;
          end else begin
            state_d = S_DRIVE;
            wr_n_d  = enable_n(src_sel);
          end
`else
          state_d = S_DRIVE;
          wr_n_d  = enable_n(src_sel);
`endif
        end
      end
      S_DRIVE: begin
        state_d = S_XFER;
        wr_n_d  = enable_n(src_q);
        rd_n_d  = enable_n(dst_q);
      end
      S_XFER: begin
        state_d = S_RELEASE;
        done_d  = grant_q;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        grant_d = '0;
        ptr_d   = (sel_q == LAST_REQ) ? '0 : sel_q + PTR_W'(1);
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, pointer, latched transfer and output registers.
  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      wr_n_q  <= '1;
      rd_n_q  <= '1;
      busy_q  <= 1'b0;
`ifdef BUS_XFER_CHECK_EN
      error_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      wr_n_q  <= wr_n_d;
      rd_n_q  <= rd_n_d;
      busy_q  <= busy_d;
`ifdef BUS_XFER_CHECK_EN
      error_q <= error_d;
`endif
    end
  end

  assign o_GRANT       = grant_q;
  assign o_DONE        = done_q;
  assign o_WRITE_BUS_n = wr_n_q;
  assign o_READ_BUS_n  = rd_n_q;
  assign o_BUSY        = busy_q;
`ifdef BUS_XFER_CHECK_EN
  assign o_ERROR       = error_q;
`endif

endmodule
